// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller.
//   - funct3 access-size encodings (LDST_*)
//   - FSM state enum
//   - byte-lane mask constants and an access-width helper
package lsu_ctrl_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StWrite,
    StDone
  } lsu_state_e;

  // Lane masks at lane 0; shifted by 8*addr[1:0] to reach the target lane.
  localparam logic [31:0] ByteLaneMask = 32'h0000_00ff;
  localparam logic [31:0] HalfLaneMask = 32'h0000_ffff;

  // Bytes touched by an access; 0 flags an illegal size encoding.
  function automatic logic [2:0] access_bytes(input logic [2:0] size);
    logic [2:0] n;
    case (size)
      LDST_B, LDST_BU: n = 3'd1;
      LDST_H, LDST_HU: n = 3'd2;
      LDST_W:          n = 3'd4;
      default:         n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store controller.
//   size_i       funct3 access size
//   offset_i     byte offset within the word (addr[1:0])
//   old_word_i   word read from data memory
//   new_data_i   right-aligned store data
//   load_data_o  selected lane, sign- or zero-extended
//   store_word_o old_word_i with the store lane(s) replaced by new_data_i
module lsu_lane_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [4:0]  shamt;
  logic [15:0] lane_data;
  logic [31:0] lane_mask;

  assign shamt     = {offset_i, 3'b000};
  // Halfword accesses are 2-byte aligned, so the shift always lands the half in [15:0].
  assign lane_data = 16'(old_word_i >> shamt);

  always_comb begin
    load_data_o = '0;
    case (size_i)
      LDST_B:  load_data_o = {{24{lane_data[7]}}, lane_data[7:0]};
      LDST_H:  load_data_o = {{16{lane_data[15]}}, lane_data[15:0]};
      LDST_W:  load_data_o = old_word_i;
      LDST_BU: load_data_o = {24'b0, lane_data[7:0]};
      LDST_HU: load_data_o = {16'b0, lane_data[15:0]};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    lane_mask = '1;
    case (size_i)
      LDST_B, LDST_BU: lane_mask = ByteLaneMask << shamt;
      LDST_H, LDST_HU: lane_mask = HalfLaneMask << shamt;
      default:         lane_mask = '1;
    endcase
  end

  assign store_word_o = (old_word_i & ~lane_mask) | ((new_data_i << shamt) & lane_mask);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the core memory stage and a word-wide data memory.
// Sub-word stores are done as read-modify-write since the memory writes whole words.
//   clk, rst            clock, synchronous active-high reset
//   core_req_i/we_i     request strobe and direction (1 = store)
//   core_size_i         funct3 size (B/H/W/BU/HU)
//   core_addr_i         byte address
//   core_wdata_i        right-aligned store data
//   core_rdata_o        last extended load result
//   core_stall_o        core holds its request while high
//   core_done_o/err_o   one-cycle completion pulse and error flag
//   mem_req_o/we_o      data memory strobe and write enable
//   mem_addr_o          word-aligned memory address
//   mem_wdata_o         memory write word
//   mem_rdata_i         combinational memory read data
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic [31:0]       core_rdata_o,
  output logic              core_stall_o,
  output logic              core_done_o,
  output logic              core_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [ADDR_W:0] MemLimit = (ADDR_W + 1)'(MEM_BYTES);

  lsu_state_e        state_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;  // store data, replaced by the merged word in RMW_RD
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic [2:0]        req_bytes;
  logic [ADDR_W:0]   req_end;
  logic              req_misaligned;
  logic              req_oor;
  logic              req_bad;
  logic              mem_active;

  // Legality of the incoming request; one extra address bit keeps addr + bytes from wrapping.
  always_comb begin
    req_bytes      = access_bytes(core_size_i);
    req_misaligned = ((core_size_i == LDST_H || core_size_i == LDST_HU) && core_addr_i[0]) ||
                     (core_size_i == LDST_W && core_addr_i[1:0] != 2'b00);
    req_end        = {1'b0, core_addr_i} + {{(ADDR_W - 2){1'b0}}, req_bytes};
    req_oor        = req_end > MemLimit;
    req_bad        = (req_bytes == 3'd0) || req_misaligned || req_oor;
  end

  lsu_lane_align u_lane_align (
    .size_i       (size_q),
    .offset_i     (addr_q[1:0]),
    .old_word_i   (mem_rdata_i),
    .new_data_i   (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (core_req_i) begin
            size_q  <= core_size_i;
            addr_q  <= core_addr_i;
            wdata_q <= core_wdata_i;
            err_q   <= req_bad;
            if (req_bad) begin
              state_q <= StDone;
            end else if (!core_we_i) begin
              state_q <= StLoad;
            end else if (core_size_i == LDST_W) begin
              state_q <= StWrite;
            end else begin
              state_q <= StRmwRd;
            end
          end
        end
        StLoad: begin
          rdata_q <= load_data;
          state_q <= StDone;
        end
        StRmwRd: begin
          wdata_q <= store_word;
          state_q <= StWrite;
        end
        StWrite: state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_active   = (state_q == StLoad) || (state_q == StRmwRd) || (state_q == StWrite);
  assign mem_req_o    = mem_active;
  assign mem_we_o     = (state_q == StWrite);
  assign mem_addr_o   = mem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata_o  = (state_q == StWrite) ? wdata_q : '0;
  assign core_stall_o = ((state_q == StIdle) && core_req_i) || mem_active;
  assign core_done_o  = (state_q == StDone);
  assign core_err_o   = (state_q == StDone) && err_q;
  assign core_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int MEM_BYTES = 1024;

  logic        clk;
  logic        rst;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [31:0] core_rdata_o;
  logic        core_stall_o;
  logic        core_done_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  lsu_ctrl #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_rdata_o (core_rdata_o),
    .core_stall_o (core_stall_o),
    .core_done_o  (core_done_o),
    .core_err_o   (core_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide data memory with combinational read; preload port for the bench.
  logic [31:0] dmem [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) dmem[pl_idx] <= pl_data;
    else if (mem_req_o && mem_we_o) dmem[mem_addr_o[9:2]] <= mem_wdata_o;
  end
  assign mem_rdata_i = dmem[mem_addr_o[9:2]];

  // Reference model: byte-addressed memory plus last load value.
  logic [7:0]  rmem [MEM_BYTES];
  logic [31:0] ref_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  task automatic ref_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic e_err, output int e_lat,
                        output int e_mreq);
    int     n;
    longint v;
    n = nbytes(sz);
    if (n == 0 || (a % n) != 0 || longint'(a) + n > MEM_BYTES) begin
      e_err = 1'b1; e_lat = 1; e_mreq = 0;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(rmem[int'(a) + i]) << (8 * i));
      if ((sz == 3'd0 || sz == 3'd1) && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      ref_rdata = 32'(v);
      e_err = 1'b0; e_lat = 2; e_mreq = 1;
    end else begin
      for (int i = 0; i < n; i++) rmem[int'(a) + i] = wd[8*i +: 8];
      e_err  = 1'b0;
      e_lat  = (n == 4) ? 2 : 3;
      e_mreq = (n == 4) ? 1 : 2;
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 8'(idx); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) rmem[idx * 4 + i] = d[8*i +: 8];
  endtask

  // Issues one request at the next falling edge (cycle 0) and follows it to done.
  // shape_ok covers the stall pattern and idle/active memory-bus values.
  task automatic run_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output int lat,
                        output logic err, output logic [31:0] rd, output int mreq,
                        output bit shape_ok);
    lat = -1; err = 1'b0; rd = '0; mreq = 0; shape_ok = 1'b1;
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = a; core_wdata_i = wd;
    #1;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (mem_req_o) begin
        mreq++;
        if (mem_addr_o !== {a[31:2], 2'b00}) shape_ok = 1'b0;
      end else if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
        shape_ok = 1'b0;
      end
      if (core_done_o === 1'b1) begin
        lat = c; err = core_err_o; rd = core_rdata_o;
        if (core_stall_o !== 1'b0) shape_ok = 1'b0;
        if (!hold) core_req_i = 1'b0;
      end else if (core_stall_o !== 1'b1) begin
        shape_ok = 1'b0;
      end
    end
    if (lat < 0) core_req_i = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_mreq;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t        v;
    int          lat, mreq, e_lat, e_mreq, mism;
    logic        err, e_err, we;
    logic [31:0] rd, a, wd, w;
    logic [2:0]  sz;
    bit          shp;
    int          mode;

    rst = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = '0;
    core_addr_i = '0; core_wdata_i = '0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    ref_rdata = '0;

    for (int i = 0; i < 256; i++) preload(i, $urandom);
    preload(4, 32'h8899AABB);
    preload(8, 32'h11223344);
    preload(255, 32'hCAFEF00D);
    preload(20, 32'hA1B2C3D4);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", core_rdata_o, 32'h0);
    chk("rst_flags", {27'b0, core_stall_o, core_done_o, core_err_o, mem_req_o, mem_we_o}, 32'h0);
    chk("rst_maddr", mem_addr_o, 32'h0);
    chk("rst_mwdata", mem_wdata_o, 32'h0);

    //          we    size  addr           wdata          err   lat mreq rdata
    vecs.push_back('{1'b0, 3'd2, 32'h10,       32'h0,        1'b0, 2, 1, 32'h8899AABB});
    vecs.push_back('{1'b0, 3'd0, 32'h13,       32'h0,        1'b0, 2, 1, 32'hFFFFFF88});
    vecs.push_back('{1'b0, 3'd4, 32'h13,       32'h0,        1'b0, 2, 1, 32'h00000088});
    vecs.push_back('{1'b1, 3'd0, 32'h21,       32'h5A,       1'b0, 3, 2, 32'h00000088});
    vecs.push_back('{1'b0, 3'd2, 32'h20,       32'h0,        1'b0, 2, 1, 32'h11225A44});
    vecs.push_back('{1'b1, 3'd1, 32'h23,       32'hBEEF,     1'b1, 1, 0, 32'h11225A44});
    vecs.push_back('{1'b0, 3'd2, 32'h12,       32'h0,        1'b1, 1, 0, 32'h11225A44});
    vecs.push_back('{1'b0, 3'd3, 32'h10,       32'h0,        1'b1, 1, 0, 32'h11225A44});
    vecs.push_back('{1'b0, 3'd2, 32'h400,      32'h0,        1'b1, 1, 0, 32'h11225A44});
    vecs.push_back('{1'b0, 3'd0, 32'h400,      32'h0,        1'b1, 1, 0, 32'h11225A44});
    vecs.push_back('{1'b0, 3'd2, 32'h20,       32'h0,        1'b0, 2, 1, 32'h11225A44});
    vecs.push_back('{1'b0, 3'd2, 32'h3FC,      32'h0,        1'b0, 2, 1, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 3'd5, 32'h3FE,      32'h0,        1'b0, 2, 1, 32'h0000CAFE});
    vecs.push_back('{1'b0, 3'd0, 32'h3FF,      32'h0,        1'b0, 2, 1, 32'hFFFFFFCA});
    vecs.push_back('{1'b0, 3'd1, 32'h3FE,      32'h0,        1'b0, 2, 1, 32'hFFFFCAFE});
    vecs.push_back('{1'b0, 3'd1, 32'h10,       32'h0,        1'b0, 2, 1, 32'hFFFFAABB});
    vecs.push_back('{1'b1, 3'd1, 32'h12,       32'h12347777, 1'b0, 3, 2, 32'hFFFFAABB});
    vecs.push_back('{1'b0, 3'd2, 32'h10,       32'h0,        1'b0, 2, 1, 32'h7777AABB});
    vecs.push_back('{1'b1, 3'd2, 32'h30,       32'hDEADBEEF, 1'b0, 2, 1, 32'h7777AABB});
    vecs.push_back('{1'b0, 3'd2, 32'h30,       32'h0,        1'b0, 2, 1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'd6, 32'h30,       32'h0,        1'b1, 1, 0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 3'd7, 32'h30,       32'h0,        1'b1, 1, 0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'd2, 32'h3FD,      32'h0,        1'b1, 1, 0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,        1'b1, 1, 0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'd2, 32'h30,       32'h0,        1'b0, 2, 1, 32'hDEADBEEF});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      ref_op(v.we, v.size, v.addr, v.wdata, e_err, e_lat, e_mreq);
      run_op(v.we, v.size, v.addr, v.wdata, 1'b0, lat, err, rd, mreq, shp);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, v.exp_err});
      chk($sformatf("vec%0d_lat", i), lat, v.exp_lat);
      chk($sformatf("vec%0d_mreq", i), mreq, v.exp_mreq);
      chk($sformatf("vec%0d_rdata", i), rd, v.exp_rdata);
      chk($sformatf("vec%0d_shape", i), {31'b0, shp}, 32'h1);
    end

    // Back-to-back SW then LW with the request held high across done.
    ref_op(1'b1, 3'd2, 32'h40, 32'h5EED1234, e_err, e_lat, e_mreq);
    run_op(1'b1, 3'd2, 32'h40, 32'h5EED1234, 1'b1, lat, err, rd, mreq, shp);
    chk("b2b_sw_lat", lat, 2);
    chk("b2b_sw_shape", {31'b0, shp}, 32'h1);
    ref_op(1'b0, 3'd2, 32'h40, 32'h0, e_err, e_lat, e_mreq);
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, lat, err, rd, mreq, shp);
    chk("b2b_lw_lat", lat, 2);
    chk("b2b_lw_shape", {31'b0, shp}, 32'h1);
    chk("b2b_lw_rdata", rd, 32'h5EED1234);

    // Reset during RMW_RD of a byte store: no write, everything idle.
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd0;
    core_addr_i = 32'h51; core_wdata_i = 32'hEE;
    @(negedge clk);
    chk("rmw_rd_active", {30'b0, mem_req_o, mem_we_o}, 32'h2);
    rst = 1'b1; core_req_i = 1'b0;
    @(negedge clk);
    chk("rstrmw_flags", {27'b0, core_stall_o, core_done_o, core_err_o, mem_req_o, mem_we_o}, 32'h0);
    chk("rstrmw_bus", mem_addr_o | mem_wdata_o, 32'h0);
    chk("rstrmw_rdata", core_rdata_o, 32'h0);
    rst = 1'b0;
    ref_rdata = '0;
    @(negedge clk);
    chk("rstrmw_nodone", {31'b0, core_done_o}, 32'h0);
    chk("rstrmw_mem", dmem[20], 32'hA1B2C3D4);

    // Reset during WRITE of a word store: the write lands, done never pulses.
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
    core_addr_i = 32'h54; core_wdata_i = 32'h0BADF00D;
    @(negedge clk);
    chk("write_active", {30'b0, mem_req_o, mem_we_o}, 32'h3);
    rst = 1'b1; core_req_i = 1'b0;
    @(negedge clk);
    chk("rstwr_nodone0", {31'b0, core_done_o}, 32'h0);
    chk("rstwr_mem", dmem[21], 32'h0BADF00D);
    rst = 1'b0;
    w = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) rmem[84 + i] = w[8*i +: 8];
    @(negedge clk);
    chk("rstwr_nodone1", {31'b0, core_done_o}, 32'h0);
    @(negedge clk);
    chk("rstwr_nodone2", {31'b0, core_done_o}, 32'h0);

    // Randomised traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      we   = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 3);
      wd   = $urandom;
      a    = $urandom_range(0, MEM_BYTES - 1);
      case (mode)
        0:       a = a & ~32'(nbytes(sz) - 1);
        2:       a = $urandom_range(MEM_BYTES - 8, MEM_BYTES + 7);
        3:       a = $urandom;
        default: ;
      endcase
      ref_op(we, sz, a, wd, e_err, e_lat, e_mreq);
      run_op(we, sz, a, wd, 1'b0, lat, err, rd, mreq, shp);
      chk($sformatf("rnd%0d_err", k), {31'b0, err}, {31'b0, e_err});
      chk($sformatf("rnd%0d_lat", k), lat, e_lat);
      chk($sformatf("rnd%0d_mreq", k), mreq, e_mreq);
      chk($sformatf("rnd%0d_rdata", k), rd, ref_rdata);
      chk($sformatf("rnd%0d_shape", k), {31'b0, shp}, 32'h1);
    end

    @(negedge clk);
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      w = {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
      if (dmem[i] !== w) mism++;
    end
    chk("mem_final_mismatch_words", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
